// File: rtl/load_store_unit.sv
// Load/store unit for an RV32I-style core: accepts one byte/half/word access
// at a time, performs read-modify-write for sub-word stores on a word-wide
// simple dual-port RAM, and returns an extended load result or a fault flag.

module bram_sdp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    parameter     INIT  = ""
) (
    input  logic                     wr_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Whole-word write port.
    always_ff @(posedge wr_clk) begin
        if (wr_en) r_mem[wr_addr] <= wr_data;
    end

    // Registered read port: data valid the cycle after rd_en.
    always_ff @(posedge rd_clk) begin
        if (rd_en) rd_data <= r_mem[rd_addr];
    end
endmodule

module load_store_unit #(
    parameter int DEPTH    = 128,
    parameter     MEM_INIT = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        access_fault
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_store, r_fault;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [AW-1:0]     r_idx;
    logic [31:0]       r_wdata;
    logic [31:0]       w_rd_data;
    logic              w_read_enable, w_write_enable;
    logic              w_accept, w_fault;

    // Select and extend the addressed lane of a loaded word.
    function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  f_load_ext = {{24{b[7]}}, b};
            3'b001:  f_load_ext = {{16{h[15]}}, h};
            3'b100:  f_load_ext = {24'd0, sh[7:0]};
            3'b101:  f_load_ext = {16'd0, sh[15:0]};
            default: f_load_ext = word;
        endcase
    endfunction

    // Merge a byte/halfword store into the previously read word.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] data,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  off);
        logic [31:0] mask, d;
        case (f3[1:0])
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                d    = {4{data[7:0]}};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                d    = {2{data[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                d    = data;
            end
        endcase
        f_merge = (word & ~mask) | (d & mask);
    endfunction

    // Misalignment, reserved width codes and unsigned store codes all fault.
    always_comb begin
        w_fault = 1'b0;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) w_fault = 1'b1;
        if (is_store && (funct3 == 3'b100 || funct3 == 3'b101))       w_fault = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])                          w_fault = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)                   w_fault = 1'b1;
    end

    assign w_accept = req_valid && req_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake/memory-strobe decode; reset forces all strobes low.
    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        access_fault   = 1'b0;
        w_read_enable  = 1'b0;
        w_write_enable = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid) begin
                    if (w_fault)                            w_next = RESP;
                    else if (is_store && funct3 == 3'b010)  w_next = WRITE;
                    else                                    w_next = READ;
                end
            end
            READ: begin
                w_read_enable = !reset;
                w_next        = WAIT;
            end
            WAIT:  w_next = r_store ? WRITE : RESP;
            WRITE: begin
                w_write_enable = !reset;
                w_next         = RESP;
            end
            RESP: begin
                resp_valid   = !reset;
                access_fault = !reset && r_fault;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch, read-modify-write merge and load result register.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_data <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_store <= is_store;
                r_f3    <= funct3;
                r_off   <= addr[1:0];
                r_idx   <= addr[AW+1:2];
                r_wdata <= store_data;
                r_fault <= w_fault;
                if (w_fault) load_data <= 32'd0;
            end
            if (r_state == WAIT) begin
                if (r_store) r_wdata   <= f_merge(w_rd_data, r_wdata, r_f3, r_off);
                else         load_data <= f_load_ext(w_rd_data, r_f3, r_off);
            end
        end
    end

    bram_sdp #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .INIT  (MEM_INIT)
    ) u_mem (
        .wr_clk  (clock),
        .wr_en   (w_write_enable),
        .wr_addr (r_idx),
        .wr_data (r_wdata),
        .rd_clk  (clock),
        .rd_en   (w_read_enable),
        .rd_addr (r_idx),
        .rd_data (w_rd_data)
    );
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 128, meaning number of 32-bit data words.
REQ-002 The block SHALL have parameter MEM_INIT, default "", meaning the data memory init file ("" = no init).
REQ-003 The block SHALL have port clock  in  1  meaning the single clock; all state changes on posedge.
REQ-004 The block SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  in  1  meaning an access request is presented.
REQ-006 The block SHALL have port req_ready  out  1  meaning the unit is idle and accepts a request this cycle.
REQ-007 The block SHALL have port is_store  in  1  meaning 1 = store, 0 = load.
REQ-008 The block SHALL have port funct3  in  3  meaning RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 The block SHALL have port addr  in  32  meaning the byte address (rs1 + imm).
REQ-010 The block SHALL have port store_data  in  32  meaning the store source (rs2), with the low bits used for B/H.
REQ-011 The block SHALL have port resp_valid  out  1  meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port load_data  out  32  meaning the extended load result, held until the next response.
REQ-013 The block SHALL have port access_fault  out  1  meaning misaligned or illegal access, qualified by resp_valid.

Function
REQ-014 The block SHALL instantiate bram_sdp (WIDTH 32, DEPTH DEPTH, INIT MEM_INIT) with both clocks tied to clock, whole-word writes only, and registered read data valid one cycle after read_enable.
REQ-015 The block SHALL form the word index from addr[$clog2(DEPTH)+1:2], ignore higher bits, and alias addresses modulo 4*DEPTH bytes.
REQ-016 The block SHALL implement FSM states IDLE, READ, WAIT, WRITE and RESP.
REQ-017 The block SHALL assert req_ready only in IDLE, and SHALL accept a request on a posedge where req_valid and req_ready are both 1, latching is_store, funct3, addr and store_data.
REQ-018 The block SHALL treat as faults: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
REQ-019 On accept, the block SHALL transition: fault -> RESP; SW -> WRITE; all others -> READ.
REQ-020 The block SHALL drive read_enable=1 with the latched index in READ, then go to WAIT.
REQ-021 In WAIT, for a load, the block SHALL select the byte/halfword by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), register the result into load_data, and go to RESP.
REQ-022 In WAIT, for SB/SH, the block SHALL merge store_data[7:0] or [15:0] into the read word at the lane given by addr[1:0], leave other lanes unchanged, and go to WRITE.
REQ-023 In WRITE, the block SHALL drive write_enable=1 with the merged word (SB/SH) or store_data (SW) for exactly one cycle, then go to RESP.
REQ-024 In RESP, the block SHALL set resp_valid=1 for exactly one cycle and return to IDLE; access_fault SHALL be 1 only for faulted requests.
REQ-025 Latency from the accept edge to the resp_valid cycle SHALL be: fault 1, SW 2, loads 3, SB/SH 4 cycles.
REQ-026 The block SHALL leave memory unchanged on a fault, set load_data=0 on a fault, and leave load_data unchanged on stores.
REQ-027 The block SHALL ignore req_valid while not in IDLE and SHALL NOT queue it; a request held high is accepted on the first IDLE cycle.
REQ-028 The block SHALL never assert read_enable and write_enable in the same cycle.

Reset
REQ-029 While reset=1, the block SHALL go to IDLE, drive req_ready=0, resp_valid=0, access_fault=0, load_data=0, write_enable=0 and read_enable=0; req_ready SHALL be 1 in the first cycle after reset falls.
REQ-030 Reset mid-operation SHALL abort the access without a write; memory contents SHALL NOT be cleared by reset.

Verification
REQ-031 SW 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_valid 2 and 3 cycles after the respective accepts; load_data=0xDEADBEEF, fault=0; LW 0x210 (DEPTH 128) -> 0xDEADBEEF.
REQ-032 SB 0x11 data 0x000000AA over 0xDEADBEEF -> LW 0x10=0xDEADAAEF; LB 0x11=0xFFFFFFAA; LBU 0x11=0x000000AA.
REQ-033 SH 0x12 data 0x00008001 -> LW 0x10=0x8001AAEF; LH 0x12=0xFFFF8001; LHU 0x12=0x00008001; SH latency 4 cycles.
REQ-034 LW 0x13, LH 0x11, funct3=011 -> resp_valid 1 cycle after accept, fault=1, load_data=0; LW 0x10 is unchanged.
REQ-035 Reset asserted in WAIT of SB 0x10 data 0x55 -> no write_enable pulse; after release req_ready=1; LW 0x10 returns the pre-store word.
REQ-036 req_valid held high for 3 back-to-back LWs -> exactly 3 resp_valid pulses, each accept 1 cycle after the prior RESP, and req_ready low otherwise.
